// File: rtl/prio_enc_disp_if.sv
// Request/result bundle for prio_enc_disp: request controls in, registered
// result, change count and seven-segment patterns out.
interface prio_enc_disp_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned W = $clog2(N);

  logic [N-1:0] data;
  logic         enable;
  logic         mode_low;
  logic         hold;
  logic [W-1:0] idx;
  logic         valid;
  logic [7:0]   change_cnt;
  logic [7:0]   seg_idx;
  logic [7:0]   seg_cnt_lo;
  logic [7:0]   seg_cnt_hi;

  modport master (
    output data, enable, mode_low, hold,
    input  idx, valid, change_cnt, seg_idx, seg_cnt_lo, seg_cnt_hi
  );

  modport slave (
    input  data, enable, mode_low, hold,
    output idx, valid, change_cnt, seg_idx, seg_cnt_lo, seg_cnt_hi
  );
endinterface

// File: rtl/prio_enc_disp.sv
// Registered N-input priority encoder with selectable direction, hold, a
// result-change counter and active-low seven-segment decodes of the state.
module prio_enc_disp #(
  parameter int unsigned N = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  prio_enc_disp_if.slave   bus
);
  localparam int unsigned W = $clog2(N);

  logic [W-1:0] r_idx;
  logic         r_valid;
  logic [7:0]   r_cnt;

  logic         w_nvalid;
  logic [W-1:0] w_nidx;
  logic         w_chg;
  logic [3:0]   w_idx4;

  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  assign w_nvalid = bus.enable & (|bus.data);

  // The last match in scan order wins, so scan direction sets the priority.
  always_comb begin
    w_nidx = '0;
    if (bus.mode_low) begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (bus.data[i]) w_nidx = W'(i);
      end
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (bus.data[i]) w_nidx = W'(i);
      end
    end
    if (!w_nvalid) w_nidx = '0;
  end

  assign w_chg = (w_nvalid != r_valid) | (w_nvalid & (w_nidx != r_idx));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= 8'd0;
    end else if (!bus.hold) begin
      r_idx   <= w_nidx;
      r_valid <= w_nvalid;
      if (w_chg) r_cnt <= r_cnt + 8'd1;
    end
  end

  assign w_idx4 = 4'(r_idx);

  assign bus.idx        = r_idx;
  assign bus.valid      = r_valid;
  assign bus.change_cnt = r_cnt;
  assign bus.seg_idx    = r_valid ? hex_seg(w_idx4) : 8'hFF;
  assign bus.seg_cnt_lo = hex_seg(r_cnt[3:0]);
  assign bus.seg_cnt_hi = hex_seg(r_cnt[7:4]);
endmodule

// File: tb/tb_prio_enc_disp.sv
// Bench for prio_enc_disp (N=8): directed test-plan steps plus random traffic,
// checked against a log2-based reference model of the encoder and counter.
module tb_prio_enc_disp;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prio_enc_disp_if #(.N(N)) bus ();

  prio_enc_disp #(.N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] glyph [16];
  int m_idx, m_valid, m_cnt;

  function automatic int ref_idx(input int d, input bit low);
    int lsb;
    if (d == 0) return 0;
    if (low) begin
      lsb = d & (-d);
      return $clog2(lsb);
    end
    return $clog2(d + 1) - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".idx"}, 32'(bus.idx), 32'(m_idx));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(m_valid));
    chk({tag, ".cnt"}, 32'(bus.change_cnt), 32'(m_cnt));
    chk({tag, ".seg_idx"}, 32'(bus.seg_idx), 32'(m_valid ? glyph[m_idx] : 8'hFF));
    chk({tag, ".seg_lo"}, 32'(bus.seg_cnt_lo), 32'(glyph[m_cnt % 16]));
    chk({tag, ".seg_hi"}, 32'(bus.seg_cnt_hi), 32'(glyph[m_cnt / 16]));
  endtask

  // Drive at the falling edge, advance the model at the rising edge, check 1ns later.
  task automatic step(input logic [7:0] d, input bit en, input bit low, input bit hd,
                      input bit rs_n, input string tag);
    int nv, ni;
    @(negedge clk);
    bus.data = d; bus.enable = en; bus.mode_low = low; bus.hold = hd; rst_n = rs_n;
    @(posedge clk);
    if (!rs_n) begin
      m_idx = 0; m_valid = 0; m_cnt = 0;
    end else if (!hd) begin
      nv = (en && d != 0) ? 1 : 0;
      ni = nv ? ref_idx(int'(d), low) : 0;
      if (nv != m_valid || (nv == 1 && ni != m_idx)) m_cnt = (m_cnt + 1) % 256;
      m_idx = ni; m_valid = nv;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    glyph = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    m_idx = 0; m_valid = 0; m_cnt = 0;
    rst_n = 1'b0;
    bus.data = '0; bus.enable = 1'b0; bus.mode_low = 1'b0; bus.hold = 1'b0;

    // Reset then idle
    step(8'h00, 1, 0, 0, 0, "rst0");
    step(8'h00, 1, 0, 0, 0, "rst1");
    chk("rst.seg_idx", 32'(bus.seg_idx), 32'hFF);
    chk("rst.seg_lo", 32'(bus.seg_cnt_lo), 32'h03);
    step(8'h00, 1, 0, 0, 1, "idle");
    chk("idle.cnt", 32'(bus.change_cnt), 32'd0);

    // Priority direction
    step(8'b0010_1100, 1, 0, 0, 1, "hi_wins");
    chk("hi_wins.idx", 32'(bus.idx), 32'd5);
    chk("hi_wins.seg", 32'(bus.seg_idx), 32'h49);
    step(8'b0010_1100, 1, 1, 0, 1, "lo_wins");
    chk("lo_wins.idx", 32'(bus.idx), 32'd2);
    chk("lo_wins.seg", 32'(bus.seg_idx), 32'h25);
    chk("lo_wins.cnt", 32'(bus.change_cnt), 32'd2);

    // Enable gating
    step(8'h80, 1, 0, 0, 1, "en1");
    step(8'h80, 0, 0, 0, 1, "en0");
    chk("en0.seg", 32'(bus.seg_idx), 32'hFF);
    chk("en0.cnt", 32'(bus.change_cnt), 32'd4);
    step(8'h00, 0, 0, 0, 1, "en0_rep");

    // Hold: result idx=3, then freeze while inputs churn
    step(8'h08, 1, 0, 0, 1, "pre_hold");
    chk("pre_hold.cnt", 32'(bus.change_cnt), 32'd5);
    for (int i = 0; i < 10; i++)
      step(8'($urandom), 1'($urandom), 1'($urandom), 1, 1, "hold");
    step(8'h08, 1, 0, 0, 1, "rel_same");
    chk("rel_same.cnt", 32'(bus.change_cnt), 32'd5);
    step(8'h10, 1, 0, 0, 1, "rel_new");
    chk("rel_new.idx", 32'(bus.idx), 32'd4);
    chk("rel_new.cnt", 32'(bus.change_cnt), 32'd6);

    // Counter wrap
    for (int i = 0; i < 260; i++) begin
      step((i % 2 == 0) ? 8'h01 : 8'h02, 1, 0, 0, 1, "wrap");
      if (m_cnt == 255) begin
        chk("wrap255.hi", 32'(bus.seg_cnt_hi), 32'h71);
        chk("wrap255.lo", 32'(bus.seg_cnt_lo), 32'h71);
      end
    end

    // Random traffic, occasional hold and reset
    for (int i = 0; i < 400; i++)
      step(8'($urandom), ($urandom_range(0, 7) != 0), 1'($urandom),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 40) != 0), "rand");

    // Reset beats hold
    step(8'h40, 1, 0, 0, 1, "pre_rbh");
    step(8'h40, 1, 0, 1, 0, "rst_hold");
    chk("rst_hold.cnt", 32'(bus.change_cnt), 32'd0);
    chk("rst_hold.seg_idx", 32'(bus.seg_idx), 32'hFF);
    step(8'h40, 1, 0, 1, 1, "post_rbh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
